// File: rtl/cva6_axi_mem_responder.sv
// cva6_axi_mem_responder
//   AXI4 subordinate that terminates one CVA6 NoC port with a RAM of 64-bit words.
//   Read and write engines are independent; each handles one burst at a time.
// Ports
//   clk_i       clock, all state on the rising edge
//   rst_i       asynchronous, active-high reset
//   axi_req_i   packed noc_req_t  (AW, W, B-ready, AR, R-ready), 374 bits
//   axi_resp_o  packed noc_resp_t (ready flags, B and R channels), 146 bits
module cva6_axi_mem_responder #(
  parameter logic [63:0] BaseAddr = 64'h8000_0000,
  parameter int unsigned MemWords = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [373:0] axi_req_i,
  output logic [145:0] axi_resp_o
);

  // Field layout of the CVA6 AXI bus: 4-bit id, 64-bit addr/data, 32-bit user.
  typedef struct packed {
    logic [3:0]  id;     logic [63:0] addr;   logic [7:0] len;   logic [2:0] size;
    logic [1:0]  burst;  logic        lock;   logic [3:0] cache; logic [2:0] prot;
    logic [3:0]  qos;    logic [3:0]  region; logic [5:0] atop;  logic [31:0] user;
  } aw_chan_t;
  typedef struct packed {
    logic [63:0] data; logic [7:0] strb; logic last; logic [31:0] user;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id; logic [1:0] resp; logic [31:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;     logic [63:0] addr;   logic [7:0] len;   logic [2:0] size;
    logic [1:0]  burst;  logic        lock;   logic [3:0] cache; logic [2:0] prot;
    logic [3:0]  qos;    logic [3:0]  region; logic [31:0] user;
  } ar_chan_t;
  typedef struct packed {
    logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; logic [31:0] user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b;
    logic r_valid; r_chan_t r;
  } resp_t;

  localparam int unsigned AddrW    = $clog2(MemWords);
  localparam logic [63:0] MemBytes = 64'(MemWords) << 3;
  localparam logic [1:0]  RespOkay = 2'b00, RespSlvErr = 2'b10, RespDecErr = 2'b11;
  localparam logic [1:0]  BurstIncr = 2'b01, BurstWrap = 2'b10;

  typedef enum logic [1:0] {WReset, WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RReset, RIdle, RData} r_state_e;

  function automatic logic in_range(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BaseAddr;
    return (addr >= BaseAddr) && (off < MemBytes);
  endfunction

  function automatic logic [AddrW-1:0] word_idx(input logic [63:0] addr);
    return AddrW'((addr - BaseAddr) >> 3);
  endfunction

  // FIXED and WRAP bursts keep the beat address; size above 3 counts as 8 bytes.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [2:0] sz;
    sz = (size > 3'd3) ? 3'd3 : size;
    return (burst == BurstIncr) ? addr + (64'd1 << sz) : addr;
  endfunction

  req_t  req;
  resp_t resp;
  assign req        = axi_req_i;
  assign axi_resp_o = resp;

  logic [63:0] mem_q [MemWords];

  // Write engine state
  w_state_e    w_state_q;
  logic [3:0]  aw_id_q, b_id_q;
  logic [63:0] w_addr_q;
  logic [7:0]  w_len_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_burst_q, b_resp_q;
  logic [5:0]  w_atop_q;
  logic [8:0]  w_cnt_q;  // saturates at 256 so extra beats never alias back into range
  logic        w_dec_q, w_dec_d;
  logic        w_hs, w_beat_ok, w_in, w_suppress, w_we;

  assign w_hs       = (w_state_q == WData) && req.w_valid;
  assign w_beat_ok  = (w_cnt_q <= {1'b0, w_len_q});
  assign w_in       = in_range(w_addr_q);
  assign w_suppress = (w_atop_q != 6'd0) || (w_burst_q == BurstWrap);
  assign w_we       = w_hs && w_beat_ok && w_in && !w_suppress;
  assign w_dec_d    = w_dec_q || (w_hs && w_beat_ok && !w_in);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= WReset;
      aw_id_q   <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_atop_q  <= '0;
      w_cnt_q   <= '0;
      w_dec_q   <= 1'b0;
      b_id_q    <= '0;
      b_resp_q  <= '0;
    end else begin
      case (w_state_q)
        WReset: w_state_q <= WIdle;
        WIdle: if (req.aw_valid) begin
          aw_id_q   <= req.aw.id;
          w_addr_q  <= req.aw.addr;
          w_len_q   <= req.aw.len;
          w_size_q  <= req.aw.size;
          w_burst_q <= req.aw.burst;
          w_atop_q  <= req.aw.atop;
          w_cnt_q   <= '0;
          w_dec_q   <= 1'b0;
          w_state_q <= WData;
        end
        WData: if (w_hs) begin
          w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
          if (!w_cnt_q[8]) w_cnt_q <= w_cnt_q + 9'd1;
          w_dec_q <= w_dec_d;
          if (req.w.last) begin
            b_id_q    <= aw_id_q;
            b_resp_q  <= w_dec_d ? RespDecErr : (w_suppress ? RespSlvErr : RespOkay);
            w_state_q <= WResp;
          end
        end
        WResp: if (req.b_ready) w_state_q <= WIdle;
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (req.w.strb[b]) mem_q[word_idx(w_addr_q)][8*b +: 8] <= req.w.data[8*b +: 8];
      end
    end
  end

  // Read engine state; the beat payload is captured at the edge that selects the beat,
  // so a same-cycle write to that word lands after the read.
  r_state_e    r_state_q;
  logic [3:0]  r_id_q;
  logic [63:0] r_addr_q, r_addr_d, rd_addr, rd_data, r_data_q;
  logic [7:0]  r_len_q, r_cnt_q;
  logic [2:0]  r_size_q;
  logic [1:0]  r_burst_q, rd_burst, rd_resp, r_resp_q;
  logic        r_last_q, ar_hs, r_hs;

  assign ar_hs    = (r_state_q == RIdle) && req.ar_valid;
  assign r_hs     = (r_state_q == RData) && req.r_ready;
  assign r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
  assign rd_addr  = ar_hs ? req.ar.addr : r_addr_d;
  assign rd_burst = ar_hs ? req.ar.burst : r_burst_q;

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    if (!in_range(rd_addr)) rd_resp = RespDecErr;
    else if (rd_burst == BurstWrap) rd_resp = RespSlvErr;
    else rd_data = mem_q[word_idx(rd_addr)];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= RReset;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state_q)
        RReset: r_state_q <= RIdle;
        RIdle: if (ar_hs) begin
          r_id_q    <= req.ar.id;
          r_addr_q  <= req.ar.addr;
          r_len_q   <= req.ar.len;
          r_size_q  <= req.ar.size;
          r_burst_q <= req.ar.burst;
          r_cnt_q   <= '0;
          r_data_q  <= rd_data;
          r_resp_q  <= rd_resp;
          r_last_q  <= (req.ar.len == 8'd0);
          r_state_q <= RData;
        end
        RData: if (r_hs) begin
          if (r_last_q) begin
            r_state_q <= RIdle;
          end else begin
            r_addr_q <= r_addr_d;
            r_cnt_q  <= r_cnt_q + 8'd1;
            r_data_q <= rd_data;
            r_resp_q <= rd_resp;
            r_last_q <= (8'(r_cnt_q + 8'd1) == r_len_q);
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  always_comb begin
    resp          = '0;
    resp.aw_ready = (w_state_q == WIdle);
    resp.w_ready  = (w_state_q == WData);
    resp.b_valid  = (w_state_q == WResp);
    resp.b.id     = b_id_q;
    resp.b.resp   = b_resp_q;
    resp.ar_ready = (r_state_q == RIdle);
    resp.r_valid  = (r_state_q == RData);
    resp.r.id     = r_id_q;
    resp.r.data   = r_data_q;
    resp.r.resp   = r_resp_q;
    resp.r.last   = r_last_q;
  end

  // Sideband fields carried on the bus but not acted on.
  logic unused_req;
  assign unused_req = ^{req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region,
                        req.aw.user, req.w.user, req.ar.lock, req.ar.cache, req.ar.prot,
                        req.ar.qos, req.ar.region, req.ar.user};

endmodule

// File: tb/tb_cva6_axi_mem_responder.sv
module tb_cva6_axi_mem_responder;

  typedef struct packed {
    logic [3:0]  id;     logic [63:0] addr;   logic [7:0] len;   logic [2:0] size;
    logic [1:0]  burst;  logic        lock;   logic [3:0] cache; logic [2:0] prot;
    logic [3:0]  qos;    logic [3:0]  region; logic [5:0] atop;  logic [31:0] user;
  } aw_chan_t;
  typedef struct packed {
    logic [63:0] data; logic [7:0] strb; logic last; logic [31:0] user;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id; logic [1:0] resp; logic [31:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;     logic [63:0] addr;   logic [7:0] len;   logic [2:0] size;
    logic [1:0]  burst;  logic        lock;   logic [3:0] cache; logic [2:0] prot;
    logic [3:0]  qos;    logic [3:0]  region; logic [31:0] user;
  } ar_chan_t;
  typedef struct packed {
    logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; logic [31:0] user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b;
    logic r_valid; r_chan_t r;
  } resp_t;

  localparam logic [63:0] Base   = 64'h8000_0000;
  localparam logic [1:0]  Okay   = 2'b00, SlvErr = 2'b10, DecErr = 2'b11;
  localparam logic [1:0]  BIncr  = 2'b01, BWrap  = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  req_t         req;
  resp_t        resp;
  logic [373:0] req_flat;
  logic [145:0] resp_flat;

  assign req_flat = req;
  assign resp     = resp_flat;

  cva6_axi_mem_responder #(.BaseAddr(Base), .MemWords(1024)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi_req_i  (req_flat),
    .axi_resp_o (resp_flat)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [1:0] resp; } exp_b_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } exp_r_t;
  exp_b_t exp_b[$];
  exp_r_t exp_r[$];
  exp_b_t eb;
  exp_r_t er;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [145:0] act, input logic [145:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected event, want handshake", name);
  endtask

  // Monitor: pops the scoreboard on every B/R handshake.
  r_chan_t r_prev;
  logic    stall_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("r_stable", resp.r, r_prev);
      if (resp.b_valid && req.b_ready) begin
        if (exp_b.size() == 0) fail("b_unexpected");
        else begin
          eb = exp_b.pop_front();
          check("b_id", resp.b.id, eb.id);
          check("b_resp", resp.b.resp, eb.resp);
          check("b_user", resp.b.user, 0);
        end
      end
      if (resp.r_valid && req.r_ready) begin
        if (exp_r.size() == 0) fail("r_unexpected");
        else begin
          er = exp_r.pop_front();
          check("r_id", resp.r.id, er.id);
          check("r_data", resp.r.data, er.data);
          check("r_resp", resp.r.resp, er.resp);
          check("r_last", resp.r.last, er.last);
          check("r_user", resp.r.user, 0);
        end
      end
      stall_prev = resp.r_valid && !req.r_ready;
      r_prev     = resp.r;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [5:0] atop);
    int i;
    req.aw = '0;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len; req.aw.size = 3'd3;
    req.aw.burst = burst; req.aw.atop = atop;
    req.aw_valid = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp.aw_ready) break;
    end
    if (i == 50) fail("aw_timeout");
    tick();
    req.aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] data, input logic last);
    int i;
    req.w = '0;
    req.w.data = data; req.w.strb = 8'hFF; req.w.last = last;
    req.w_valid = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp.w_ready) break;
    end
    if (i == 50) fail("w_timeout");
    tick();
    req.w_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    int i;
    req.ar = '0;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = 3'd3;
    req.ar.burst = burst;
    req.ar_valid = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp.ar_ready) break;
    end
    if (i == 50) fail("ar_timeout");
    check("r_valid_before_ar", resp.r_valid, 0);
    tick();
    req.ar_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0) break;
      tick();
    end
    if (i == 100) fail(name);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [5:0] atop,
                             input logic [63:0] d0, d1, d2, d3, input logic [1:0] want);
    logic [63:0] d [4];
    d = '{d0, d1, d2, d3};
    exp_b.push_back('{id: id, resp: want});
    do_aw(id, addr, len, burst, atop);
    for (int i = 0; i <= int'(len); i++) do_w(d[i], i == int'(len));
    wait_drain("b_drain");
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic toggle,
                            input logic [63:0] d0, d1, d2, d3,
                            input logic [1:0] e0, e1, e2, e3);
    logic [63:0] d [4];
    logic [1:0]  e [4];
    int got;
    d = '{d0, d1, d2, d3};
    e = '{e0, e1, e2, e3};
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{id: id, data: d[i], resp: e[i], last: (i == int'(len))});
    req.r_ready = 1'b0;
    do_ar(id, addr, len, burst);
    check("r_latency", resp.r_valid, 1);
    got = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      req.r_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (resp.r_valid && req.r_ready) got++;
      tick();
      if (got == int'(len) + 1) break;
    end
    req.r_ready = 1'b0;
    check("r_beats", got, int'(len) + 1);
    check("r_drain", exp_r.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", resp_flat, 0);
    req.b_ready = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    check("idle_ready", {resp.aw_ready, resp.ar_ready, resp.w_ready}, 3'b110);

    // 1: single beat write then read back
    write_burst(4'h1, Base + 64'h8, 8'd0, BIncr, 6'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, Okay);
    read_burst(4'h2, Base + 64'h8, 8'd0, BIncr, 1'b0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0,
               Okay, Okay, Okay, Okay);

    // 2: INCR burst, readback with r_ready toggling
    write_burst(4'h4, Base + 64'h100, 8'd3, BIncr, 6'h0, 64'd1, 64'd2, 64'd3, 64'd4, Okay);
    read_burst(4'h4, Base + 64'h100, 8'd3, BIncr, 1'b1, 64'd1, 64'd2, 64'd3, 64'd4,
               Okay, Okay, Okay, Okay);

    // 3: burst crossing the top of memory
    write_burst(4'h5, 64'h8000_1FF8, 8'd1, BIncr, 6'h0, 64'hA5A5, 64'hB6B6, 0, 0, DecErr);
    read_burst(4'h5, 64'h8000_1FF8, 8'd1, BIncr, 1'b0, 64'hA5A5, 64'd0, 0, 0,
               Okay, DecErr, Okay, Okay);

    // 4: atomic write rejected, word untouched
    write_burst(4'h6, Base + 64'h8, 8'd0, BIncr, 6'h20, 64'hFF, 0, 0, 0, SlvErr);
    read_burst(4'h6, Base + 64'h8, 8'd0, BIncr, 1'b0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0,
               Okay, Okay, Okay, Okay);

    // WRAP read: accepted, error, zero data
    read_burst(4'h7, Base + 64'h8, 8'd0, BWrap, 1'b0, 64'd0, 0, 0, 0,
               SlvErr, Okay, Okay, Okay);

    // 5: reset in the middle of a read burst
    exp_r.push_back('{id: 4'h5, data: 64'd1, resp: Okay, last: 1'b0});
    req.r_ready = 1'b0;
    do_ar(4'h5, Base + 64'h100, 8'd3, BIncr);
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_r_valid", resp.r_valid, 0);
    check("rst_ar_ready", resp.ar_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("post_rst_ready", {resp.aw_ready, resp.ar_ready}, 2'b11);
    check("rst_drain", exp_r.size(), 0);
    read_burst(4'h8, Base + 64'h100, 8'd1, BIncr, 1'b0, 64'd1, 64'd2, 0, 0,
               Okay, Okay, Okay, Okay);

    // 6: AW and AR together on one word, W beat aligned with the read beat
    write_burst(4'h1, Base + 64'h200, 8'd0, BIncr, 6'h0, 64'h1111, 0, 0, 0, Okay);
    exp_b.push_back('{id: 4'h3, resp: Okay});
    exp_r.push_back('{id: 4'hA, data: 64'h1111, resp: Okay, last: 1'b1});
    req.aw = '0;
    req.aw.id = 4'h3; req.aw.addr = Base + 64'h200; req.aw.size = 3'd3; req.aw.burst = BIncr;
    req.ar = '0;
    req.ar.id = 4'hA; req.ar.addr = Base + 64'h200; req.ar.size = 3'd3; req.ar.burst = BIncr;
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    @(negedge clk);
    check("aw_ar_ready", {resp.aw_ready, resp.ar_ready}, 2'b11);
    tick();
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    req.w = '0;
    req.w.data = 64'h2222; req.w.strb = 8'hFF; req.w.last = 1'b1;
    req.w_valid = 1'b1;
    req.r_ready = 1'b1;
    @(negedge clk);
    check("w_r_aligned", {resp.w_ready, resp.r_valid}, 2'b11);
    tick();
    req.w_valid = 1'b0;
    req.r_ready = 1'b0;
    wait_drain("concurrent_drain");
    read_burst(4'hB, Base + 64'h200, 8'd0, BIncr, 1'b0, 64'h2222, 0, 0, 0,
               Okay, Okay, Okay, Okay);

    wait_drain("final_drain");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
